sdc_reg_port_arbiter: RTL and testbench

SDC_REG_PORT_ARBITER -- requirements
Module: sdc_reg_port_arbiter

---
 rtl/sdc_reg_port_arbiter.sv | 139 +++++++++++++
 tb/tb_sdc_reg_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sdc_reg_port_arbiter.sv
// rtl/sdc_reg_port_arbiter.sv - round-robin arbiter sharing the host controller register port
// between the PUC and sequencer requesters.
module sdc_reg_port_arbiter #(
   parameter int unsigned RD_LAT      = 2,
   parameter logic [11:0] CMD_REG_IDX = 12'h00E
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_busy,
   input  logic        mreq,
   input  logic        mwe,
   input  logic [11:0] midx,
   input  logic [15:0] mwdata,
   input  logic [2:0]  mattr,
   output logic        mgnt,
   output logic        mdone,
   input  logic        sreq,
   input  logic        swe,
   input  logic [11:0] sidx,
   input  logic [15:0] swdata,
   input  logic [2:0]  sattr,
   output logic        sgnt,
   output logic        sdone,
   output logic [31:0] rdata,
   output logic        wr_reg_strb,
   output logic [11:0] wr_reg_index,
   output logic [31:0] wr_reg_output,
   output logic [2:0]  reg_attr,
   output logic [11:0] rd_reg_index,
   input  logic [31:0] rd_reg_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, ACK} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_we;
   logic [11:0] r_idx;
   logic [15:0] r_wdata;
   logic [2:0]  r_attr;
   logic        r_own_s;
   logic        r_last_s;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic        r_mgnt, r_sgnt, r_mdone, r_sdone, r_strb;
   logic [31:0] r_rdata;
   logic        w_m_elig, w_s_elig, w_grant_m, w_grant_s;
   logic        w_capture, w_strb_nxt, w_ack;

   // The requester whose done is pulsing still holds req this cycle; mask it so it is not re-granted.
   assign w_m_elig = mreq & ~r_mdone & ~(mwe & (midx == CMD_REG_IDX) & cmd_busy);
   assign w_s_elig = sreq & ~r_sdone & ~(swe & (sidx == CMD_REG_IDX) & cmd_busy);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant_m   = 1'b0;
      w_grant_s   = 1'b0;
      w_capture   = 1'b0;
      w_strb_nxt  = 1'b0;
      w_ack       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_s_elig && (!w_m_elig || !r_last_s)) w_grant_s = 1'b1;
            else if (w_m_elig)                        w_grant_m = 1'b1;
            if (w_grant_m || w_grant_s) begin
               w_state_nxt = ISSUE;
               w_cnt_nxt   = 3'(RD_LAT);
            end
         end
         ISSUE, RD_WAIT: begin
            // Read index is already on the port from the grant edge, so counting starts in ISSUE.
            if (r_we) begin
               w_strb_nxt  = 1'b1;
               w_state_nxt = ACK;
            end else if (r_cnt == 3'd1) begin
               w_capture   = 1'b1;
               w_state_nxt = ACK;
            end else begin
               w_cnt_nxt   = r_cnt - 3'd1;
               w_state_nxt = RD_WAIT;
            end
         end
         ACK: begin
            w_ack       = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= 3'd0;
         r_we     <= 1'b0;
         r_idx    <= 12'd0;
         r_wdata  <= 16'd0;
         r_attr   <= 3'd0;
         r_own_s  <= 1'b0;
         r_last_s <= 1'b1;
         r_mgnt   <= 1'b0;
         r_sgnt   <= 1'b0;
         r_mdone  <= 1'b0;
         r_sdone  <= 1'b0;
         r_strb   <= 1'b0;
         r_rdata  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mgnt  <= w_grant_m;
         r_sgnt  <= w_grant_s;
         r_strb  <= w_strb_nxt;
         r_mdone <= w_ack & ~r_own_s;
         r_sdone <= w_ack & r_own_s;
         if (w_grant_m || w_grant_s) begin
            r_own_s  <= w_grant_s;
            r_last_s <= w_grant_s;
            r_we     <= w_grant_s ? swe    : mwe;
            r_idx    <= w_grant_s ? sidx   : midx;
            r_wdata  <= w_grant_s ? swdata : mwdata;
            r_attr   <= w_grant_s ? sattr  : mattr;
         end
         if (w_capture) r_rdata <= rd_reg_data;
      end
   end

   assign mgnt          = r_mgnt;
   assign sgnt          = r_sgnt;
   assign mdone         = r_mdone;
   assign sdone         = r_sdone;
   assign wr_reg_strb   = r_strb;
   assign wr_reg_index  = r_idx;
   assign wr_reg_output = {16'h0000, r_wdata};
   assign reg_attr      = r_attr;
   assign rd_reg_index  = r_idx;
   assign rdata         = r_rdata;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_sdc_reg_port_arbiter.sv
// tb/tb_sdc_reg_port_arbiter.sv - directed bench for sdc_reg_port_arbiter.
module tb_sdc_reg_port_arbiter;

   logic        clk = 1'b0;
   logic        reset, cmd_busy;
   logic        mreq, mwe, sreq, swe;
   logic [11:0] midx, sidx;
   logic [15:0] mwdata, swdata;
   logic [2:0]  mattr, sattr;
   logic        mgnt, mdone, sgnt, sdone, wr_reg_strb, busy;
   logic [31:0] rdata, wr_reg_output, rd_reg_data;
   logic [11:0] wr_reg_index, rd_reg_index;
   logic [2:0]  reg_attr;
   int          n_cmp = 0;
   int          n_err = 0;

   sdc_reg_port_arbiter dut (
      .clk(clk), .reset(reset), .cmd_busy(cmd_busy),
      .mreq(mreq), .mwe(mwe), .midx(midx), .mwdata(mwdata), .mattr(mattr),
      .mgnt(mgnt), .mdone(mdone),
      .sreq(sreq), .swe(swe), .sidx(sidx), .swdata(swdata), .sattr(sattr),
      .sgnt(sgnt), .sdone(sdone), .rdata(rdata),
      .wr_reg_strb(wr_reg_strb), .wr_reg_index(wr_reg_index),
      .wr_reg_output(wr_reg_output), .reg_attr(reg_attr),
      .rd_reg_index(rd_reg_index), .rd_reg_data(rd_reg_data), .busy(busy)
   );

   always #10 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; cmd_busy = 1'b0; rd_reg_data = 32'h01FF0000;
      mreq = 1'b0; mwe = 1'b0; midx = 12'h000; mwdata = 16'h0000; mattr = 3'd0;
      sreq = 1'b0; swe = 1'b0; sidx = 12'h000; swdata = 16'h0000; sattr = 3'd0;
      step(); step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pulses", {26'd0, mgnt, sgnt, mdone, sdone, wr_reg_strb, 1'b0}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_wr_out", wr_reg_output, 32'd0);
      chk("rst_idx", {8'd0, wr_reg_index, rd_reg_index}, 32'd0);
      reset = 1'b0;
      step();

      // PUC write 0x02C <- 0x0007
      mreq = 1'b1; mwe = 1'b1; midx = 12'h02C; mwdata = 16'h0007; mattr = 3'd2;
      step();
      chk("w_gnt", {30'd0, mgnt, sgnt}, 32'd2);
      chk("w_busy", {31'd0, busy}, 32'd1);
      step();
      chk("w_strb", {31'd0, wr_reg_strb}, 32'd1);
      chk("w_out", wr_reg_output, 32'h00000007);
      chk("w_idx", {20'd0, wr_reg_index}, 32'h02C);
      chk("w_attr", {29'd0, reg_attr}, 32'd2);
      chk("w_gnt_pulse", {31'd0, mgnt}, 32'd0);
      step();
      chk("w_done", {30'd0, mdone, sdone}, 32'd2);
      chk("w_strb_pulse", {31'd0, wr_reg_strb}, 32'd0);
      step();
      chk("w_no_regrant", {29'd0, mgnt, mdone, busy}, 32'd0);
      mreq = 1'b0;

      // Sequencer read 0x024, data 0x01FF0000
      sreq = 1'b1; swe = 1'b0; sidx = 12'h024;
      step();
      chk("r_gnt", {30'd0, mgnt, sgnt}, 32'd1);
      chk("r_rdidx", {20'd0, rd_reg_index}, 32'h024);
      step();
      chk("r_wait_busy", {30'd0, busy, sdone}, 32'd2);
      step();
      chk("r_rdata", rdata, 32'h01FF0000);
      chk("r_no_early_done", {31'd0, sdone}, 32'd0);
      step();
      chk("r_done", {30'd0, mdone, sdone}, 32'd1);
      step();
      chk("r_no_regrant", {29'd0, sgnt, sdone, busy}, 32'd0);
      sreq = 1'b0;

      // rdata holds across a write
      rd_reg_data = 32'h12345678;
      mreq = 1'b1; mwe = 1'b1; midx = 12'h040; mwdata = 16'h1234;
      step(); step(); step();
      chk("hold_done", {31'd0, mdone}, 32'd1);
      chk("hold_rdata", rdata, 32'h01FF0000);
      step();
      mreq = 1'b0;

      // Blocked command write does not stall a PUC read
      cmd_busy = 1'b1;
      sreq = 1'b1; swe = 1'b1; sidx = 12'h00E; swdata = 16'hABCD; sattr = 3'd6;
      mreq = 1'b1; mwe = 1'b0; midx = 12'h030;
      step();
      chk("cb_gnt", {30'd0, mgnt, sgnt}, 32'd2);
      step(); step(); step();
      chk("cb_mdone", {30'd0, mdone, sdone}, 32'd2);
      chk("cb_rdata", rdata, 32'h12345678);
      step();
      chk("cb_blocked1", {30'd0, sgnt, busy}, 32'd0);
      mreq = 1'b0;
      step();
      chk("cb_blocked2", {30'd0, sgnt, busy}, 32'd0);
      cmd_busy = 1'b0;
      step();
      chk("cb_sgnt", {30'd0, mgnt, sgnt}, 32'd1);
      step();
      chk("cb_strb", {31'd0, wr_reg_strb}, 32'd1);
      chk("cb_idx", {20'd0, wr_reg_index}, 32'h00E);
      chk("cb_out", wr_reg_output, 32'h0000ABCD);
      chk("cb_attr", {29'd0, reg_attr}, 32'd6);
      step();
      chk("cb_sdone", {30'd0, mdone, sdone}, 32'd1);
      step();
      sreq = 1'b0;

      // Reset while in RD_WAIT aborts the read
      mreq = 1'b1; mwe = 1'b0; midx = 12'h050;
      step();
      chk("ab_gnt", {31'd0, mgnt}, 32'd1);
      step();
      chk("ab_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      step();
      chk("ab_rst_state", {30'd0, busy, mdone}, 32'd0);
      chk("ab_rst_rdata", rdata, 32'd0);
      chk("ab_rst_rdidx", {20'd0, rd_reg_index}, 32'd0);
      reset = 1'b0; mreq = 1'b0;
      step();
      chk("ab_no_done", {30'd0, mdone, busy}, 32'd0);

      // Simultaneous requests after reset: PUC first, then sequencer
      mreq = 1'b1; mwe = 1'b1; midx = 12'h02C; mwdata = 16'h0011; mattr = 3'd1;
      sreq = 1'b1; swe = 1'b1; sidx = 12'h034; swdata = 16'h0022; sattr = 3'd5;
      step();
      chk("rr_first", {30'd0, mgnt, sgnt}, 32'd2);
      step();
      chk("rr_m_out", wr_reg_output, 32'h00000011);
      step();
      chk("rr_mdone", {30'd0, mdone, sdone}, 32'd2);
      step();
      chk("rr_second", {30'd0, mgnt, sgnt}, 32'd1);
      mreq = 1'b0; midx = 12'h0FF; mwdata = 16'hFFFF; mattr = 3'd7;
      step();
      chk("rr_s_strb", {31'd0, wr_reg_strb}, 32'd1);
      chk("rr_s_out", wr_reg_output, 32'h00000022);
      chk("rr_s_idx", {20'd0, wr_reg_index}, 32'h034);
      chk("rr_s_attr", {29'd0, reg_attr}, 32'd5);
      step();
      chk("rr_sdone", {30'd0, mdone, sdone}, 32'd1);
      step();
      sreq = 1'b0;
      chk("rr_idle", {29'd0, mgnt, sgnt, busy}, 32'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
